// File: rtl/bg_sub_pkg.sv
// Shared types and helpers for the background-subtraction statistics block.
package bg_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_PIX_W = 5;
  localparam int DEF_ACC_W = 20;
  localparam int DEF_CNT_W = 17;

  // Add two values, clamping at the all-ones value of a 'width'-bit field (width < 32).
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] inc,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, acc} + {1'b0, inc};
    max_v = (33'd1 << width) - 33'd1;
    if (sum > max_v) begin
      sat_add = max_v[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  // True when the same addition had to clamp.
  function automatic logic sat_hit(input logic [31:0] acc, input logic [31:0] inc,
                                   input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum     = {1'b0, acc} + {1'b0, inc};
    max_v   = (33'd1 << width) - 33'd1;
    sat_hit = (sum > max_v);
  endfunction

endpackage

// File: rtl/bg_subtract_stats_if.sv
// Pixel-in / result-out bundle of the background-subtraction statistics block.
interface bg_subtract_stats_if
  import bg_sub_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             pix_valid;
  logic             sof;
  logic             eof;
  logic             bg_mode;
  logic [PIX_W-1:0] current_frame;
  logic [PIX_W-1:0] reference_frame;
  logic             out_valid;
  logic [PIX_W-1:0] diff_out;
  logic             fg_mask;
  logic [PIX_W-1:0] bg_out;
  logic             frame_done;
  logic [ACC_W-1:0] frame_sum;
  logic [CNT_W-1:0] fg_count;
  logic             motion;
  logic             sat;
  logic             frame_abort;

  modport master (
    output pix_valid, sof, eof, bg_mode, current_frame, reference_frame,
    input  out_valid, diff_out, fg_mask, bg_out, frame_done, frame_sum, fg_count,
           motion, sat, frame_abort
  );

  modport slave (
    input  pix_valid, sof, eof, bg_mode, current_frame, reference_frame,
    output out_valid, diff_out, fg_mask, bg_out, frame_done, frame_sum, fg_count,
           motion, sat, frame_abort
  );
endinterface

// File: rtl/bg_abs_diff.sv
// Stage 1: registered |cur - ref|, foreground threshold and selective background update.
module bg_abs_diff #(
  parameter int PIX_W  = 5,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             sof,
  input  logic             eof,
  input  logic             bg_mode,
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  output logic             out_valid,
  output logic             sof_q,
  output logic             eof_q,
  output logic             fg_mask,
  output logic [PIX_W-1:0] diff_out,
  output logic [PIX_W-1:0] bg_out
);
  localparam logic [PIX_W:0]   THRESH_W = THRESH[PIX_W:0];
  localparam logic [PIX_W-1:0] ONE_W    = {{(PIX_W-1){1'b0}}, 1'b1};

  logic [PIX_W:0]   delta_s;
  logic [PIX_W:0]   mag_s;
  logic [PIX_W-1:0] diff_s;
  logic [PIX_W-1:0] bg_s;
  logic             fg_s;

  // Difference and background step; +1/-1 only when cur differs, so it never wraps.
  always_comb begin
    delta_s = {1'b0, cur_pix} - {1'b0, ref_pix};
    if (delta_s[PIX_W]) begin
      mag_s = (~delta_s) + {{PIX_W{1'b0}}, 1'b1};
    end else begin
      mag_s = delta_s;
    end
    diff_s = mag_s[PIX_W-1:0];
    fg_s   = ({1'b0, diff_s} > THRESH_W);
    if (!bg_mode || fg_s) begin
      bg_s = ref_pix;
    end else if (cur_pix > ref_pix) begin
      bg_s = ref_pix + ONE_W;
    end else if (cur_pix < ref_pix) begin
      bg_s = ref_pix - ONE_W;
    end else begin
      bg_s = ref_pix;
    end
  end

  // Stage-1 pipeline register; frame markers travel with their pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      fg_mask   <= 1'b0;
      diff_out  <= '0;
      bg_out    <= '0;
    end else begin
      out_valid <= pix_valid;
      sof_q     <= pix_valid & sof;
      eof_q     <= pix_valid & eof;
      fg_mask   <= fg_s;
      diff_out  <= diff_s;
      bg_out    <= bg_s;
    end
  end
endmodule

// File: rtl/bg_subtract_stats.sv
// Background subtraction with per-frame difference sum, foreground count and motion flag.
module bg_subtract_stats
  import bg_sub_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int THRESH     = 4,
  parameter int MOTION_MIN = 64
) (
  input logic            pclk,
  input logic            reset,
  bg_subtract_stats_if.slave bus
);
  localparam logic [31:0] MOTION_MIN_W = MOTION_MIN;

  logic             s1_valid_s, s1_sof_s, s1_eof_s, s1_fg_s;
  logic [PIX_W-1:0] s1_diff_s, s1_bg_s;

  state_e           state_r, state_n;
  logic [ACC_W-1:0] run_sum_r, sum_n, frame_sum_r;
  logic [CNT_W-1:0] run_cnt_r, cnt_n, fg_count_r;
  logic             run_sat_r, rsat_n, sat_r, motion_r;
  logic             frame_done_r, frame_abort_r;
  logic             accept_s, start_s, abort_n, done_n, base_sat_s, sum_ovf_s, cnt_ovf_s;
  logic [31:0]      base_sum_s, base_cnt_s, add_sum_s, add_cnt_s;
  logic             unused_hi_s;

  bg_abs_diff #(.PIX_W(PIX_W), .THRESH(THRESH)) u_abs_diff (
    .clk(pclk), .rst_n(reset),
    .pix_valid(bus.pix_valid), .sof(bus.sof), .eof(bus.eof), .bg_mode(bus.bg_mode),
    .cur_pix(bus.current_frame), .ref_pix(bus.reference_frame),
    .out_valid(s1_valid_s), .sof_q(s1_sof_s), .eof_q(s1_eof_s),
    .fg_mask(s1_fg_s), .diff_out(s1_diff_s), .bg_out(s1_bg_s)
  );

  // Frame FSM; DONE behaves like IDLE so a frame may start the cycle after eof.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    start_s  = 1'b0;
    abort_n  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (s1_valid_s && s1_sof_s) begin
          accept_s = 1'b1;
          start_s  = 1'b1;
          state_n  = s1_eof_s ? DONE : ACCUM;
        end else begin
          state_n = IDLE;
        end
      end
      ACCUM: begin
        if (s1_valid_s) begin
          accept_s = 1'b1;
          start_s  = s1_sof_s;
          abort_n  = s1_sof_s;
          state_n  = s1_eof_s ? DONE : ACCUM;
        end else begin
          state_n = ACCUM;
        end
      end
      default: state_n = IDLE;
    endcase

    base_sum_s = start_s ? 32'd0 : 32'(run_sum_r);
    base_cnt_s = start_s ? 32'd0 : 32'(run_cnt_r);
    base_sat_s = start_s ? 1'b0 : run_sat_r;
    add_sum_s  = sat_add(base_sum_s, 32'(s1_diff_s), ACC_W);
    sum_ovf_s  = sat_hit(base_sum_s, 32'(s1_diff_s), ACC_W);
    add_cnt_s  = sat_add(base_cnt_s, {31'd0, s1_fg_s}, CNT_W);
    cnt_ovf_s  = sat_hit(base_cnt_s, {31'd0, s1_fg_s}, CNT_W);

    if (accept_s) begin
      sum_n  = add_sum_s[ACC_W-1:0];
      cnt_n  = add_cnt_s[CNT_W-1:0];
      rsat_n = base_sat_s | sum_ovf_s | cnt_ovf_s;
    end else begin
      sum_n  = run_sum_r;
      cnt_n  = run_cnt_r;
      rsat_n = run_sat_r;
    end
    done_n = accept_s & s1_eof_s;
  end

  // Upper bits are always zero after clamping to the narrower field.
  assign unused_hi_s = ^{add_sum_s[31:ACC_W], add_cnt_s[31:CNT_W]};

  // State, accumulators and frame results; results latch as the FSM enters DONE.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      run_sum_r     <= '0;
      run_cnt_r     <= '0;
      run_sat_r     <= 1'b0;
      frame_sum_r   <= '0;
      fg_count_r    <= '0;
      motion_r      <= 1'b0;
      sat_r         <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      run_sum_r     <= sum_n;
      run_cnt_r     <= cnt_n;
      run_sat_r     <= rsat_n;
      frame_done_r  <= done_n;
      frame_abort_r <= abort_n;
      if (done_n) begin
        frame_sum_r <= sum_n;
        fg_count_r  <= cnt_n;
        sat_r       <= rsat_n;
        motion_r    <= (32'(cnt_n) >= MOTION_MIN_W);
      end
    end
  end

  assign bus.out_valid   = s1_valid_s;
  assign bus.diff_out    = s1_diff_s;
  assign bus.fg_mask     = s1_fg_s;
  assign bus.bg_out      = s1_bg_s;
  assign bus.frame_done  = frame_done_r;
  assign bus.frame_sum   = frame_sum_r;
  assign bus.fg_count    = fg_count_r;
  assign bus.motion      = motion_r;
  assign bus.sat         = sat_r;
  assign bus.frame_abort = frame_abort_r;
endmodule

// File: tb/tb_bg_subtract_stats.sv
// Scoreboard bench: two instances (wide and narrow accumulators) share one pixel stream.
module tb_bg_subtract_stats;
  localparam int A_ACC = 20, A_CNT = 17, B_ACC = 8, B_CNT = 3, MOT = 64;

  logic pclk = 1'b0;
  logic reset = 1'b0;
  logic pv = 1'b0, sf = 1'b0, ef = 1'b0, md = 1'b0;
  logic [4:0] cur = 5'd0, rf = 5'd0;

  always #5 pclk = ~pclk;

  bg_subtract_stats_if #(.PIX_W(5), .ACC_W(A_ACC), .CNT_W(A_CNT)) bus_a ();
  bg_subtract_stats_if #(.PIX_W(5), .ACC_W(B_ACC), .CNT_W(B_CNT)) bus_b ();

  assign bus_a.pix_valid = pv;  assign bus_b.pix_valid = pv;
  assign bus_a.sof = sf;        assign bus_b.sof = sf;
  assign bus_a.eof = ef;        assign bus_b.eof = ef;
  assign bus_a.bg_mode = md;    assign bus_b.bg_mode = md;
  assign bus_a.current_frame = cur;   assign bus_b.current_frame = cur;
  assign bus_a.reference_frame = rf;  assign bus_b.reference_frame = rf;

  bg_subtract_stats #(.PIX_W(5), .ACC_W(A_ACC), .CNT_W(A_CNT), .THRESH(4), .MOTION_MIN(MOT))
    dut_a (.pclk(pclk), .reset(reset), .bus(bus_a));
  bg_subtract_stats #(.PIX_W(5), .ACC_W(B_ACC), .CNT_W(B_CNT), .THRESH(4), .MOTION_MIN(MOT))
    dut_b (.pclk(pclk), .reset(reset), .bus(bus_b));

  typedef struct { int diff; int fg; int bg; int cyc; } pix_t;
  typedef struct { int sum; int cnt; int cyc; } frm_t;

  pix_t pix_q[$];
  frm_t fa_q[$];
  frm_t fb_q[$];
  int   ab_q[$];
  int   cyc = 0;
  int   total = 0, bad = 0;
  bit   in_frame = 1'b0;
  int   run_sum = 0, run_cnt = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int w);
    int max_v;
    max_v = (1 << w) - 1;
    return (v > max_v) ? max_v : v;
  endfunction

  // Drive one valid pixel and record what both DUTs must produce for it.
  task automatic drive(input bit s, input bit e, input bit m, input int c, input int r);
    int d, f, b;
    @(negedge pclk); #1;
    pv = 1'b1; sf = s; ef = e; md = m; cur = c[4:0]; rf = r[4:0];
    d = (c > r) ? c - r : r - c;
    f = (d > 4) ? 1 : 0;
    if (!m || f == 1) b = r;
    else if (c > r)   b = r + 1;
    else if (c < r)   b = r - 1;
    else              b = r;
    pix_q.push_back('{d, f, b, cyc + 1});
    if (s) begin
      if (in_frame) ab_q.push_back(cyc + 2);
      in_frame = 1'b1; run_sum = 0; run_cnt = 0;
    end
    if (in_frame) begin
      run_sum += d; run_cnt += f;
      if (e) begin
        fa_q.push_back('{run_sum, run_cnt, cyc + 2});
        fb_q.push_back('{run_sum, run_cnt, cyc + 2});
        in_frame = 1'b0;
      end
    end
  endtask

  // Invalid cycles carry junk data and stray markers that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk); #1;
      pv = 1'b0; sf = 1'($urandom); ef = 1'($urandom); md = 1'($urandom);
      cur = 5'($urandom); rf = 5'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov"},   int'(bus_a.out_valid), 0);
    check({tag, "_diff"}, int'(bus_a.diff_out), 0);
    check({tag, "_fg"},   int'(bus_a.fg_mask), 0);
    check({tag, "_bg"},   int'(bus_a.bg_out), 0);
    check({tag, "_done"}, int'(bus_a.frame_done), 0);
    check({tag, "_sum"},  int'(bus_a.frame_sum), 0);
    check({tag, "_cnt"},  int'(bus_a.fg_count), 0);
    check({tag, "_mot"},  int'(bus_a.motion), 0);
    check({tag, "_sat"},  int'(bus_a.sat), 0);
    check({tag, "_abt"},  int'(bus_a.frame_abort), 0);
    check({tag, "_sumb"}, int'(bus_b.frame_sum), 0);
    check({tag, "_satb"}, int'(bus_b.sat), 0);
  endtask

  // Monitor: pop expectations whenever a DUT presents a result.
  always @(negedge pclk) begin : mon
    pix_t p;
    frm_t fr;
    int   ab;
    if (bus_a.out_valid) begin
      if (pix_q.size() == 0) check("pix_extra", 1, 0);
      else begin
        p = pix_q.pop_front();
        check("diff", int'(bus_a.diff_out), p.diff);
        check("fg", int'(bus_a.fg_mask), p.fg);
        check("bg", int'(bus_a.bg_out), p.bg);
        check("pix_lat", cyc, p.cyc);
        check("diff_b", int'(bus_b.diff_out), p.diff);
      end
    end
    if (bus_a.frame_done) begin
      if (fa_q.size() == 0) check("done_extra_a", 1, 0);
      else begin
        fr = fa_q.pop_front();
        check("sum_a", int'(bus_a.frame_sum), clamp(fr.sum, A_ACC));
        check("cnt_a", int'(bus_a.fg_count), clamp(fr.cnt, A_CNT));
        check("mot_a", int'(bus_a.motion), (clamp(fr.cnt, A_CNT) >= MOT) ? 1 : 0);
        check("sat_a", int'(bus_a.sat),
              (fr.sum > clamp(fr.sum, A_ACC) || fr.cnt > clamp(fr.cnt, A_CNT)) ? 1 : 0);
        check("done_lat_a", cyc, fr.cyc);
      end
    end
    if (bus_b.frame_done) begin
      if (fb_q.size() == 0) check("done_extra_b", 1, 0);
      else begin
        fr = fb_q.pop_front();
        check("sum_b", int'(bus_b.frame_sum), clamp(fr.sum, B_ACC));
        check("cnt_b", int'(bus_b.fg_count), clamp(fr.cnt, B_CNT));
        check("mot_b", int'(bus_b.motion), (clamp(fr.cnt, B_CNT) >= MOT) ? 1 : 0);
        check("sat_b", int'(bus_b.sat),
              (fr.sum > clamp(fr.sum, B_ACC) || fr.cnt > clamp(fr.cnt, B_CNT)) ? 1 : 0);
        check("done_lat_b", cyc, fr.cyc);
      end
    end
    if (bus_a.frame_abort) begin
      if (ab_q.size() == 0) check("abort_extra", 1, 0);
      else begin
        ab = ab_q.pop_front();
        check("abort_lat", cyc, ab);
      end
    end
  end

  initial begin
    int r;
    // Reset state
    repeat (2) @(negedge pclk);
    check_zero("rst0");
    #1 reset = 1'b1;
    idle(2);

    // Per-pixel datapath outside any frame
    drive(0, 0, 0, 20, 3);
    drive(0, 0, 0, 3, 7);
    drive(0, 0, 1, 9, 7);
    drive(0, 0, 1, 5, 7);
    drive(0, 0, 1, 31, 0);
    drive(0, 0, 0, 9, 7);
    drive(0, 0, 1, 12, 12);
    drive(0, 1, 1, 0, 31);
    idle(3);

    // 100-pixel frame: 70 x diff 10, 30 x diff 0, with gaps
    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, 21);
      drive(i == 0, i == 99, 1'($urandom), ((i % 10) < 7) ? r + 10 : r, r);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);

    // Frame with 10 foreground pixels -> no motion
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 21);
      drive(i == 0, i == 19, 1'b1, (i % 2 == 0) ? r + 10 : r, r);
    end
    idle(3);

    // Abort at pixel 5, then the restarted frame
    for (int i = 0; i < 4; i++) drive(i == 0, 0, 0, 6, 0);
    for (int i = 0; i < 6; i++) drive(i == 0, i == 5, 0, (i == 2) ? 25 : 3, (i == 2) ? 2 : 0);
    idle(3);

    // Single-pixel frame
    drive(1, 1, 1, 31, 0);
    idle(3);

    // Saturating frame followed back-to-back by another frame
    for (int i = 0; i < 10; i++) drive(i == 0, i == 9, 0, 31, 0);
    for (int i = 0; i < 3; i++) drive(i == 0, i == 2, 0, 4 + i, 0);
    drive(1, 1, 0, 0, 17);
    idle(3);

    // Reset mid-frame: everything clears, nothing reported for the partial frame
    for (int i = 0; i < 4; i++) drive(i == 0, 0, 1, 20, 1);
    @(negedge pclk); #1;
    reset = 1'b0; pv = 1'b0;
    pix_q.delete(); fa_q.delete(); fb_q.delete(); ab_q.delete(); in_frame = 1'b0;
    @(negedge pclk);
    check_zero("rst1");
    #1 reset = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) drive(i == 0, i == 3, 0, 8 * i, 1);

    idle(8);
    check("pix_q_empty", pix_q.size(), 0);
    check("fa_q_empty", fa_q.size(), 0);
    check("fb_q_empty", fb_q.size(), 0);
    check("ab_q_empty", ab_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
